// File: rtl/dsp_pkg.sv
// Shared constants for the DSP MAC sequencer: FSM state encodings and the
// X / Z post-adder mux select encodings of the slice.
package dsp_pkg;

  // FSM states (plain constants so older tools and netlists see fixed codes)
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // X mux selects
  localparam logic [1:0] X_ZERO = 2'b00;
  localparam logic [1:0] X_M    = 2'b01;
  localparam logic [1:0] X_P    = 2'b10;
  localparam logic [1:0] X_DAB  = 2'b11;

  // Z mux selects
  localparam logic [1:0] Z_ZERO = 2'b00;
  localparam logic [1:0] Z_PCIN = 2'b01;
  localparam logic [1:0] Z_P    = 2'b10;
  localparam logic [1:0] Z_C    = 2'b11;

endpackage

// File: rtl/dsp_mac_sequencer_tap_counter.sv
// Tap index counter: synchronous clear, increment on accept, and a
// terminal-count flag raised while the count equals the supplied limit.
module tap_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // clear wins over increment so a new START always restarts from 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + W'(1);
  end

  assign tc = (cnt == limit);

endmodule

// File: rtl/dsp_mac_sequencer.sv
// MAC sequencer for one DSP slice: steps the coefficient index, drives the
// X/Z post-adder selects and M/P enables for an N-tap dot product, and
// pulses DONE once the final P value has settled.
module dsp_mac_sequencer import dsp_pkg::*; #(
  parameter int TAP_CNT_WIDTH = 8,
  parameter int PIPE_LAT      = 2,
  parameter int X_SEL_SIZE    = 2,
  parameter int Z_SEL_SIZE    = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [TAP_CNT_WIDTH-1:0] NUM_TAPS,
  input  logic                     ROUND_EN,
  input  logic                     SAMPLE_VALID,
  output logic                     SAMPLE_READY,
  output logic [TAP_CNT_WIDTH-1:0] TAP_IDX,
  output logic [X_SEL_SIZE-1:0]    X_SEL,
  output logic [Z_SEL_SIZE-1:0]    Z_SEL,
  output logic                     CEM,
  output logic                     CEP,
  output logic                     BUSY,
  output logic                     DONE
);

  localparam int DW = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT);

  logic [1:0]               state_q, state_d;
  logic [TAP_CNT_WIDTH-1:0] nt_q;
  logic                     rnd_q;
  logic [DW-1:0]            drn_q;
  logic                     start_acc, accept, tap_tc, last_acc, drn_last;
  logic [1:0]               z_first;

  assign start_acc    = (state_q == S_IDLE) && START;
  assign SAMPLE_READY = (state_q == S_RUN);
  assign BUSY         = (state_q != S_IDLE);
  assign accept       = SAMPLE_READY && SAMPLE_VALID;
  assign CEM          = accept;
  assign last_acc     = accept && tap_tc;
  assign drn_last     = (drn_q == '0);
  assign z_first      = rnd_q ? Z_C : Z_ZERO;

  // the counter register itself is the registered TAP_IDX output
  tap_counter #(.W(TAP_CNT_WIDTH)) u_tap (
    .clk   (CLK),
    .rst   (RST),
    .clr   (start_acc),
    .inc   (accept),
    .limit (nt_q - TAP_CNT_WIDTH'(1)),
    .cnt   (TAP_IDX),
    .tc    (tap_tc)
  );

  // next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START) state_d = (NUM_TAPS != '0) ? S_RUN : S_CLEAR;
      S_CLEAR: state_d = S_DRAIN;
      S_RUN:   if (last_acc) state_d = S_DRAIN;
      S_DRAIN: if (drn_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state register and per-operation latches
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      nt_q    <= '0;
      rnd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        nt_q  <= NUM_TAPS;
        rnd_q <= ROUND_EN;
      end
    end
  end

  // drain down-counter: preloaded outside DRAIN, so DRAIN lasts PIPE_LAT cycles
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                     drn_q <= '0;
    else if (state_q != S_DRAIN) drn_q <= DW'(PIPE_LAT - 1);
    else if (!drn_last)          drn_q <= drn_q - DW'(1);
  end

  // registered slice controls: default is "P holds", a beat follows each accept
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      X_SEL <= X_SEL_SIZE'(X_ZERO);
      Z_SEL <= Z_SEL_SIZE'(Z_P);
      CEP   <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      X_SEL <= X_SEL_SIZE'(X_ZERO);
      Z_SEL <= Z_SEL_SIZE'(Z_P);
      CEP   <= 1'b0;
      DONE  <= (state_q == S_DRAIN) && drn_last;
      if (accept) begin
        X_SEL <= X_SEL_SIZE'(X_M);
        CEP   <= 1'b1;
        if (TAP_IDX == '0) Z_SEL <= Z_SEL_SIZE'(z_first);
      end else if (state_q == S_CLEAR) begin
        CEP   <= 1'b1;
        Z_SEL <= Z_SEL_SIZE'(z_first);
      end
    end
  end

endmodule
